// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
// Frame layout: R/W bit, address, data, MSB first.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WDATA,
    RDATA
  } spi_state_e;

  localparam logic SPI_OP_WRITE = 1'b1;
  localparam logic SPI_OP_READ  = 1'b0;

  function automatic int frame_len(
    input int addr_w,
    input int data_w
  );
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin with
// registered rising/falling edge pulses aligned to q.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {STAGES{RST_VAL}};
      q    <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      q    <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~q;
      fall <= ~sync[STAGES-1] & q;
    end
  end

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 register file: writes commit on cs release,
// reads stream the addressed register back on CIPO.
module spi_regfile_peripheral
  import spi_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       spi_sclk,
  input  logic                       spi_copi,
  input  logic                       spi_cs,
  output logic                       spi_cipo,
  output logic                       spi_cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       rd_strobe,
  output logic                       frame_err
);

  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADDR_W);

  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic copi_q, copi_rise, copi_fall;

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sclk (
    .clk  (clk),
    .rst  (rst),
    .d    (spi_sclk),
    .q    (sclk_q),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_cs (
    .clk  (clk),
    .rst  (rst),
    .d    (spi_cs),
    .q    (cs_q),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_copi (
    .clk  (clk),
    .rst  (rst),
    .d    (spi_copi),
    .q    (copi_q),
    .rise (copi_rise),
    .fall (copi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_q, copi_rise, copi_fall};

  spi_state_e                 state;
  logic [CNT_W-1:0]           cnt;
  logic [FRAME_LEN-1:0]       sr;
  logic [DATA_W-1:0]          out_sr;
  logic [NUM_REGS*DATA_W-1:0] regs_q;
  logic                       pend;
  logic                       armed;
  logic [SYNC_STAGES+1:0]     settle;

  // After reset, edges are ignored until cs is seen high again,
  // so a frame cut by reset cannot resume half way through.
  logic cs_fall_v, cs_rise_v;
  assign cs_fall_v = armed & cs_fall;
  assign cs_rise_v = armed & cs_rise;

  logic [ADDR_W:0]   hdr_now;
  logic [ADDR_W-1:0] hdr_addr;
  assign hdr_now  = {sr[ADDR_W-1:0], copi_q};
  assign hdr_addr = hdr_now[ADDR_W-1:0];

  logic              f_rw;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_data;
  logic              f_inr;
  assign f_rw   = sr[FRAME_LEN-1];
  assign f_addr = sr[FRAME_LEN-2 -: ADDR_W];
  assign f_data = sr[DATA_W-1:0];
  assign f_inr  = 32'(f_addr) < 32'(NUM_REGS);

  logic [DATA_W-1:0] rd_data;

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (hdr_addr == ADDR_W'(k)) begin
        rd_data = regs_q[k*DATA_W +: DATA_W];
      end
    end
  end

  logic ok_write, ok_read;
  assign ok_write = (cnt == CNT_FULL) & (f_rw == SPI_OP_WRITE) & f_inr;
  assign ok_read  = (cnt == CNT_FULL) & (f_rw == SPI_OP_READ) & f_inr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sr          <= '0;
      out_sr      <= '0;
      regs_q      <= '0;
      pend        <= 1'b0;
      armed       <= 1'b0;
      settle      <= '0;
      spi_cipo_oe <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      rd_strobe   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      frame_err <= 1'b0;
      pend      <= 1'b0;
      settle    <= {settle[SYNC_STAGES:0], 1'b1};

      if (!armed && settle[SYNC_STAGES+1] && cs_q) begin
        armed <= 1'b1;
      end

      if (pend) begin
        if (ok_write) begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if (f_addr == ADDR_W'(k)) begin
              regs_q[k*DATA_W +: DATA_W] <= f_data;
            end
          end
          wr_strobe <= 1'b1;
          wr_addr   <= f_addr;
        end else if (!ok_read) begin
          frame_err <= 1'b1;
        end
      end

      if (cs_fall_v) begin
        state       <= ADDR;
        cnt         <= '0;
        out_sr      <= '0;
        spi_cipo_oe <= 1'b0;
      end else if (cs_rise_v) begin
        state       <= IDLE;
        out_sr      <= '0;
        spi_cipo_oe <= 1'b0;
        pend        <= (state != IDLE);
      end else if (state != IDLE && sclk_rise) begin
        if (cnt != CNT_SAT) begin
          cnt <= cnt + CNT_W'(1);
        end
        if (cnt < CNT_FULL) begin
          sr <= {sr[FRAME_LEN-2:0], copi_q};
        end
        if (state == ADDR && cnt == CNT_LAST) begin
          if (hdr_now[ADDR_W] == SPI_OP_WRITE) begin
            state <= WDATA;
          end else begin
            state       <= RDATA;
            out_sr      <= rd_data;
            rd_strobe   <= 1'b1;
            spi_cipo_oe <= 1'b1;
          end
        end
      end else if (state == RDATA && sclk_fall && cnt > CNT_HDR) begin
        // The MSB is held over the first fall; shifting starts
        // only once the controller has sampled a data bit.
        out_sr <= out_sr << 1;
      end
    end
  end

  assign spi_cipo = out_sr[DATA_W-1];
  assign regs_out = regs_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Randomised and directed bench for the SPI register file,
// covering default and 16x16 register configurations.
module tb_spi_regfile_peripheral;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst;
  logic sclk, copi, cs0, cs1;

  logic         cipo0, oe0, wr0, rd0, err0;
  logic [39:0]  regs0;
  logic [6:0]   wa0;
  logic         cipo1, oe1, wr1, rd1, err1;
  logic [255:0] regs1;
  logic [3:0]   wa1;

  always #5 clk = ~clk;

  spi_regfile_peripheral dut0 (
    .clk         (clk),
    .rst         (rst),
    .spi_sclk    (sclk),
    .spi_copi    (copi),
    .spi_cs      (cs0),
    .spi_cipo    (cipo0),
    .spi_cipo_oe (oe0),
    .regs_out    (regs0),
    .wr_strobe   (wr0),
    .wr_addr     (wa0),
    .rd_strobe   (rd0),
    .frame_err   (err0)
  );

  spi_regfile_peripheral #(
    .NUM_REGS (16),
    .DATA_W   (16),
    .ADDR_W   (4)
  ) dut1 (
    .clk         (clk),
    .rst         (rst),
    .spi_sclk    (sclk),
    .spi_copi    (copi),
    .spi_cs      (cs1),
    .spi_cipo    (cipo1),
    .spi_cipo_oe (oe1),
    .regs_out    (regs1),
    .wr_strobe   (wr1),
    .wr_addr     (wa1),
    .rd_strobe   (rd1),
    .frame_err   (err1)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] m0 [16];
  logic [15:0] m1 [16];

  int n_wr [2];
  int n_rd [2];
  int n_err [2];
  int seen_wa [2];

  logic cap_cipo [64];
  logic cap_oe [64];

  always @(negedge clk) begin
    if (!rst) begin
      if (wr0) begin n_wr[0]++; seen_wa[0] = int'(wa0); end
      if (rd0) n_rd[0]++;
      if (err0) n_err[0]++;
      if (wr1) begin n_wr[1]++; seen_wa[1] = int'(wa1); end
      if (rd1) n_rd[1]++;
      if (err1) n_err[1]++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      n_wr[i] = 0; n_rd[i] = 0; n_err[i] = 0; seen_wa[i] = -1;
    end
  endtask

  task automatic clear_models();
    for (int i = 0; i < 16; i++) begin
      m0[i] = '0; m1[i] = '0;
    end
  endtask

  task automatic clock_bits(input int which, input logic [63:0] v,
                            input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = v[i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      cap_cipo[n-1-i] = (which == 0) ? cipo0 : cipo1;
      cap_oe[n-1-i]   = (which == 0) ? oe0 : oe1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic check_regs(input string tag);
    logic [39:0]  e0;
    logic [255:0] e1;
    for (int k = 0; k < 5; k++) e0[k*8 +: 8] = m0[k][7:0];
    for (int k = 0; k < 16; k++) e1[k*16 +: 16] = m1[k];
    checks++;
    if (regs0 !== e0) begin
      errors++;
      $display("FAIL %s regs0 got %h want %h", tag, regs0, e0);
    end
    checks++;
    if (regs1 !== e1) begin
      errors++;
      $display("FAIL %s regs1 got %h want %h", tag, regs1, e1);
    end
  endtask

  task automatic run_frame(input int which, input logic rw,
                           input int addr, input logic [15:0] data,
                           input int n, input string tag);
    int aw, dw, nr, fl;
    int e_wr, e_rd, e_err;
    logic [63:0] fr, v;
    logic [15:0] e_data, got;
    logic inr, full_read, oe_ok;
    aw = (which == 0) ? 7 : 4;
    dw = (which == 0) ? 8 : 16;
    nr = (which == 0) ? 5 : 16;
    fl = 1 + aw + dw;
    addr = addr & ((1 << aw) - 1);
    if (dw == 8) data[15:8] = 8'h00;
    fr = (64'(rw) << (aw + dw)) | (64'(addr) << dw) | 64'(data);
    if (n <= fl) v = fr >> (fl - n);
    else v = (fr << (n - fl)) | 64'($urandom_range(0, (1 << (n - fl)) - 1));
    inr = addr < nr;
    e_wr = 0; e_rd = 0; e_err = 0; e_data = '0; full_read = 1'b0;
    if (n == fl) begin
      if (rw) begin
        if (inr) e_wr = 1; else e_err = 1;
      end else begin
        e_rd = 1;
        full_read = 1'b1;
        if (inr) e_data = (which == 0) ? m0[addr] : m1[addr];
        else e_err = 1;
      end
    end else begin
      e_err = 1;
      if (!rw && n >= 1 + aw) e_rd = 1;
    end
    clear_counts();
    if (which == 0) cs0 = 1'b0; else cs1 = 1'b0;
    clock_bits(which, v, n);
    repeat (HALF) @(negedge clk);
    if (which == 0) cs0 = 1'b1; else cs1 = 1'b1;
    repeat (6) @(negedge clk);
    if (full_read) begin
      checks++;
      if (((which == 0) ? oe0 : oe1) !== 1'b0) begin
        errors++;
        $display("FAIL %s oe_drop got 1 want 0", tag);
      end
    end
    repeat (10) @(negedge clk);
    if (e_wr == 1) begin
      if (which == 0) m0[addr] = data; else m1[addr] = data;
    end
    checks++;
    if (n_wr[which] != e_wr) begin
      errors++;
      $display("FAIL %s wr_strobe count got %0d want %0d", tag,
               n_wr[which], e_wr);
    end
    if (e_wr == 1) begin
      checks++;
      if (seen_wa[which] != addr) begin
        errors++;
        $display("FAIL %s wr_addr got %0d want %0d", tag,
                 seen_wa[which], addr);
      end
    end
    checks++;
    if (n_rd[which] != e_rd) begin
      errors++;
      $display("FAIL %s rd_strobe count got %0d want %0d", tag,
               n_rd[which], e_rd);
    end
    checks++;
    if (n_err[which] != e_err) begin
      errors++;
      $display("FAIL %s frame_err count got %0d want %0d", tag,
               n_err[which], e_err);
    end
    if (full_read) begin
      got = '0;
      oe_ok = 1'b1;
      for (int j = 0; j < dw; j++) begin
        got[dw-1-j] = cap_cipo[1+aw+j];
        if (cap_oe[1+aw+j] !== 1'b1) oe_ok = 1'b0;
      end
      checks++;
      if (got !== e_data) begin
        errors++;
        $display("FAIL %s read_data got %h want %h", tag, got, e_data);
      end
      checks++;
      if (!oe_ok) begin
        errors++;
        $display("FAIL %s oe_during_data got 0 want 1", tag);
      end
    end
    check_regs(tag);
  endtask

  task automatic test_reset();
    checks++;
    if ({cipo0, oe0, wr0, rd0, err0, wa0} !== '0) begin
      errors++;
      $display("FAIL reset outs0 got %b want 0",
               {cipo0, oe0, wr0, rd0, err0, wa0});
    end
    checks++;
    if ({cipo1, oe1, wr1, rd1, err1, wa1} !== '0) begin
      errors++;
      $display("FAIL reset outs1 got %b want 0",
               {cipo1, oe1, wr1, rd1, err1, wa1});
    end
    check_regs("reset");
  endtask

  task automatic test_write();
    run_frame(0, 1'b1, 2, 16'h00A5, 16, "write_a5");
    checks++;
    if (regs0[23:16] !== 8'hA5) begin
      errors++;
      $display("FAIL write_a5 reg2 got %h want a5", regs0[23:16]);
    end
  endtask

  task automatic test_readback();
    run_frame(0, 1'b1, 4, 16'h007F, 16, "wr_7f");
    run_frame(0, 1'b0, 4, 16'h0000, 16, "rd_7f");
    run_frame(0, 1'b0, 2, 16'h0000, 16, "rd_a5");
  endtask

  task automatic test_errors();
    run_frame(0, 1'b1, 3, 16'h0011, 12, "short_wr");
    run_frame(0, 1'b1, 5, 16'h00FF, 16, "oor_wr");
    run_frame(0, 1'b0, 9, 16'h0000, 16, "oor_rd");
    run_frame(0, 1'b1, 1, 16'h0042, 19, "long_wr");
    run_frame(0, 1'b0, 2, 16'h0000, 10, "short_rd");
  endtask

  task automatic test_reset_midframe();
    logic [63:0] v;
    clear_counts();
    v = 64'({1'b1, 7'd0, 8'h55}) >> 7;
    cs0 = 1'b0;
    clock_bits(0, v, 9);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_models();
    check_regs("midrst_clear");
    repeat (10) @(negedge clk);
    cs0 = 1'b1;
    repeat (16) @(negedge clk);
    checks++;
    if (n_err[0] != 0 || n_wr[0] != 0) begin
      errors++;
      $display("FAIL midrst_quiet err/wr got %0d/%0d want 0/0",
               n_err[0], n_wr[0]);
    end
    run_frame(0, 1'b1, 1, 16'h003C, 16, "midrst_wr");
    checks++;
    if (regs0[15:0] !== 16'h3C00) begin
      errors++;
      $display("FAIL midrst reg1_reg0 got %h want 3c00", regs0[15:0]);
    end
  endtask

  task automatic test_wide();
    run_frame(1, 1'b1, 15, 16'hBEEF, 21, "wide_wr");
    checks++;
    if (regs1[255:240] !== 16'hBEEF) begin
      errors++;
      $display("FAIL wide reg15 got %h want beef", regs1[255:240]);
    end
    run_frame(1, 1'b0, 15, 16'h0000, 21, "wide_rd");
  endtask

  task automatic test_random();
    int which, fl, n, addr;
    logic rw;
    for (int t = 0; t < 30; t++) begin
      which = (t % 4 == 3) ? 1 : 0;
      fl = (which == 0) ? 16 : 21;
      rw = 1'($urandom_range(0, 1));
      addr = (which == 0) ? int'($urandom_range(0, 7))
                          : int'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) addr = int'($urandom_range(0, 127));
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, fl + 4)) : fl;
      run_frame(which, rw, addr, 16'($urandom), n, "random");
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 5; k++) begin
      run_frame(0, 1'b1, k, 16'(8'h10 + 8'(k)), 16, "b2b_wr");
    end
    for (int k = 0; k < 5; k++) begin
      run_frame(0, 1'b0, k, 16'h0000, 16, "b2b_rd");
    end
  endtask

  initial begin
    rst = 1'b1;
    sclk = 1'b0;
    copi = 1'b0;
    cs0 = 1'b1;
    cs1 = 1'b1;
    clear_models();
    clear_counts();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    test_reset();
    test_write();
    test_readback();
    test_errors();
    test_reset_midframe();
    test_wide();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
